// File: rtl/fft_pkg.sv
`default_nettype none
// fft_pkg: shared widths, sample/word types and serializer state encoding for the FFT output path.
package fft_pkg;

  localparam int DW      = 16;
  localparam int N_WORDS = 64;
  localparam int LANES   = 4;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sample_t;

  typedef sample_t [LANES-1:0] word_t;

  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } oser_state_e;

endpackage
`default_nettype wire

// File: rtl/fft_oser_fifo.sv
`default_nettype none
// fft_oser_fifo: synchronous word FIFO with next-cycle occupancy; drops pushes while full.
// FFT_OSER_OVF_EN adds a sticky overflow flag, otherwise ovf_o is tied low. Rev 1.0
module fft_oser_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   occ_next_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q, occ_q;
  logic [AW:0]      wr_ptr_d, rd_ptr_d, occ_d;
  logic             full, pop_ok, push_ok;

  assign full    = (occ_q == DEPTH_W);
  assign empty_o = (occ_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the write would otherwise be refused.
  assign push_ok = push_i & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) occ_d = occ_q + 1'b1;
    else if (!push_ok && pop_ok) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign occ_next_o = occ_d;

`ifdef FFT_OSER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf_q <= 1'b0;
    else if (push_i && full && !pop_ok)  ovf_q <= 1'b1;
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/fft_out_serializer.sv
`default_nettype none
// fft_out_serializer: captures 4-lane FFT output words into a FIFO and streams them one sample per handshake.
// FFT_OSER_OVF_EN enables the sticky overflow flag on ovf_o (detected in fft_oser_fifo). Rev 1.0
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int DW      = fft_pkg::DW,
  parameter int N_WORDS = fft_pkg::N_WORDS,
  parameter int DEPTH   = 64,
  parameter int RD_LAT  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            done_i,
  input  logic [2*DW-1:0] din0_i,
  input  logic [2*DW-1:0] din1_i,
  input  logic [2*DW-1:0] din2_i,
  input  logic [2*DW-1:0] din3_i,
  output logic            start_ok_o,
  output logic [2*DW-1:0] dout_o,
  output logic            dout_valid_o,
  input  logic            dout_ready_i,
  output logic            dout_last_o,
  output logic            ovf_o
);

  localparam int SW  = 2*DW;
  localparam int AW  = $clog2(DEPTH);
  localparam int FS  = LANES*N_WORDS;
  localparam int FCW = $clog2(FS);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FS-1);
  localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]    NW_W    = (AW+1)'(N_WORDS);

  logic [RD_LAT-1:0]          done_dly_q;
  logic                       we;
  logic [LANES-1:0][SW-1:0]   fifo_rdata;
  logic [LANES-1:0][SW-1:0]   lanes_q;
  logic                       fifo_empty, pop, hs, li_wrap, hold_valid;
  logic [AW:0]                occ_next;
  logic [1:0]                 li_q, li_d;
  logic [FCW-1:0]             fcnt_q, fcnt_d;
  logic                       start_ok_q, start_ok_d;
  oser_state_e                state_q, state_d;

  // Align DONE with the buffer read latency so the write strobe meets valid lane data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_dly_q <= '0;
    end else begin
      done_dly_q[0] <= done_i;
      for (int i = 1; i < RD_LAT; i++) done_dly_q[i] <= done_dly_q[i-1];
    end
  end

  assign we = done_dly_q[RD_LAT-1];

  fft_oser_fifo #(
    .WIDTH (LANES*SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (we),
    .wdata_i    ({din3_i, din2_i, din1_i, din0_i}),
    .pop_i      (pop),
    .rdata_o    (fifo_rdata),
    .empty_o    (fifo_empty),
    .occ_next_o (occ_next),
    .ovf_o      (ovf_o)
  );

  assign hold_valid = (state_q == ST_LOADED);
  assign hs         = hold_valid & dout_ready_i;
  assign li_wrap    = hs & (li_q == 2'd3);
  // Reload while lane 3 leaves so consecutive words stream without a bubble.
  assign pop        = ~fifo_empty & (~hold_valid | li_wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY:  if (pop) state_d = ST_LOADED;
      ST_LOADED: if (li_wrap && !pop) state_d = ST_EMPTY;
      default:   state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    dout_valid_o = hold_valid;
    dout_o       = lanes_q[li_q];
    dout_last_o  = hold_valid && (fcnt_q == FC_LAST);
    start_ok_o   = start_ok_q;
  end

  always_comb begin
    li_d       = hs ? li_q + 2'd1 : li_q;
    fcnt_d     = fcnt_q;
    if (hs) fcnt_d = (fcnt_q == FC_LAST) ? '0 : fcnt_q + 1'b1;
    start_ok_d = (DEPTH_W - occ_next) >= NW_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q    <= '0;
      li_q       <= 2'd0;
      fcnt_q     <= '0;
      start_ok_q <= 1'b1;
    end else begin
      if (pop) lanes_q <= fifo_rdata;
      li_q       <= li_d;
      fcnt_q     <= fcnt_d;
      start_ok_q <= start_ok_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_out_serializer.sv
`default_nettype none
// tb_fft_out_serializer: table-driven frames plus hand sequences, checked against a sample-queue model.
// Expects OVF only when FFT_OSER_OVF_EN is defined. Rev 1.0
module tb_fft_out_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din0, din1, din2, din3;
  logic        done0, done1, rdy0, rdy1;
  logic        start_ok0, val0, last0, ovf0;
  logic        start_ok1, val1, last1, ovf1;
  logic [31:0] dout0, dout1;

  int checks = 0;
  int errors = 0;
  int rmode0 = 0, rmode1 = 0;
  int cnt0 = 0, cnt1 = 0, rx0 = 0, rx1 = 0, lasts0 = 0, lasts1 = 0;
  int cyc = 0, first0 = -1, last_c0 = -1, first1 = -1, last_c1 = -1;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic        pv0 = 0, pr0 = 0, pl0 = 0;
  logic [31:0] pd0 = 0;

  typedef struct {
    int nw;
    int rmode;
    bit pat;
    int exp_rx;
    int exp_lasts;
    bit contig;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  fft_out_serializer dut0 (
    .clk(clk), .rst_n(rst_n), .done_i(done0),
    .din0_i(din0), .din1_i(din1), .din2_i(din2), .din3_i(din3),
    .start_ok_o(start_ok0), .dout_o(dout0), .dout_valid_o(val0),
    .dout_ready_i(rdy0), .dout_last_o(last0), .ovf_o(ovf0)
  );

  fft_out_serializer #(.DEPTH(128)) dut1 (
    .clk(clk), .rst_n(rst_n), .done_i(done1),
    .din0_i(din0), .din1_i(din1), .din2_i(din2), .din3_i(din3),
    .start_ok_o(start_ok1), .dout_o(dout1), .dout_valid_o(val1),
    .dout_ready_i(rdy1), .dout_last_o(last1), .ovf_o(ovf1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode0)
      0: rdy0 = 1'b1;
      1: rdy0 = ~rdy0;
      2: rdy0 = 1'($urandom_range(0, 1));
      default: rdy0 = 1'b0;
    endcase
    rdy1 = (rmode1 == 0);
  end

  // Scoreboard: every accepted sample must be the next one the bench fed in, in lane order.
  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (!rst_n) begin
      pv0 = 1'b0;
    end else begin
      if (pv0 && !pr0) chk("hold0", {val0, last0, dout0}, {1'b1, pl0, pd0});
      if (val0 && rdy0) begin
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra0 actual=%0h expected=none", dout0);
        end else begin
          e = exp_q0.pop_front();
          chk("dout0", dout0, e);
        end
        chk("last0", last0, 64'((cnt0 % 256) == 255));
        if (last0) lasts0++;
        if (first0 < 0) first0 = cyc;
        last_c0 = cyc;
        cnt0++; rx0++;
      end
      if (val1 && rdy1) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra1 actual=%0h expected=none", dout1);
        end else begin
          e = exp_q1.pop_front();
          chk("dout1", dout1, e);
        end
        chk("last1", last1, 64'((cnt1 % 256) == 255));
        if (last1) lasts1++;
        if (first1 < 0) first1 = cyc;
        last_c1 = cyc;
        cnt1++; rx1++;
      end
      pv0 = val0; pr0 = rdy0; pl0 = last0; pd0 = dout0;
    end
  end

  task automatic clear_models();
    exp_q0.delete(); exp_q1.delete();
    cnt0 = 0; cnt1 = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    done0 = 0; done1 = 0; rst_n = 0;
    clear_models();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Drives nw DONE cycles; lane data follows one cycle behind. Only the first 'keep' words enter the model.
  task automatic send_frame(input int id, input int nw, input bit pat, input int keep);
    logic [31:0] w [4];
    for (int c = 0; c <= nw; c++) begin
      @(posedge clk); #1;
      if (id == 0) done0 = (c < nw); else done1 = (c < nw);
      if (c >= 1) begin
        for (int j = 0; j < 4; j++) begin
          w[j] = pat ? 32'(4*(c-1) + j) : $urandom;
          if (c - 1 < keep) begin
            if (id == 0) exp_q0.push_back(w[j]); else exp_q1.push_back(w[j]);
          end
        end
        din0 = w[0]; din1 = w[1]; din2 = w[2]; din3 = w[3];
      end
    end
  endtask

  task automatic wait_drain(input int id, input int budget);
    int n = 0;
    while (n < budget && !((id == 0) ? (exp_q0.size() == 0 && !val0)
                                     : (exp_q1.size() == 0 && !val1))) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain%0d actual=timeout expected=empty left=%0d", id,
               (id == 0) ? exp_q0.size() : exp_q1.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_rst(input string nm);
    chk(nm, {start_ok0, val0, last0, ovf0, dout0}, {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; done0 = 0; done1 = 0; rdy0 = 1; rdy1 = 1;
    din0 = 0; din1 = 0; din2 = 0; din3 = 0;
    vecs[0] = '{64, 0, 1'b1, 256, 1, 1'b1};
    vecs[1] = '{64, 1, 1'b1, 256, 1, 1'b0};
    vecs[2] = '{32, 2, 1'b0, 128, 0, 1'b0};
    vecs[3] = '{32, 2, 1'b0, 128, 1, 1'b0};
    vecs[4] = '{16, 0, 1'b0,  64, 0, 1'b1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk_rst("idle0");
    end
    chk("idle1", {start_ok1, val1, last1, ovf1, dout1}, {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});

    // Single-word latency: DONE in cycle t, write at end of t+1, DOUT valid after the next edge.
    @(posedge clk); #1 done0 = 1;
    @(posedge clk); #1 done0 = 0;
    din0 = 32'hA0; din1 = 32'hA1; din2 = 32'hA2; din3 = 32'hA3;
    exp_q0.push_back(32'hA0); exp_q0.push_back(32'hA1);
    exp_q0.push_back(32'hA2); exp_q0.push_back(32'hA3);
    @(negedge clk); chk("lat_e1", {val0, start_ok0}, {1'b0, 1'b1});
    @(negedge clk); chk("lat_e2", {val0, start_ok0}, {1'b0, 1'b0});
    @(negedge clk); chk("lat_e3", {val0, start_ok0}, {1'b1, 1'b1});
    wait_drain(0, 50);
    chk("lat_rx", rx0, 4);
    do_reset();

    for (int v = 0; v < 5; v++) begin
      rx0 = 0; lasts0 = 0; first0 = -1; last_c0 = -1;
      rmode0 = vecs[v].rmode;
      send_frame(0, vecs[v].nw, vecs[v].pat, vecs[v].nw);
      wait_drain(0, 3000);
      chk($sformatf("vec%0d_rx", v), rx0, vecs[v].exp_rx);
      chk($sformatf("vec%0d_lasts", v), lasts0, vecs[v].exp_lasts);
      chk($sformatf("vec%0d_startok", v), start_ok0, 1);
      if (vecs[v].contig)
        chk($sformatf("vec%0d_contig", v), last_c0 - first0 + 1, vecs[v].exp_rx);
    end

    do_reset();
    rmode1 = 0; rx1 = 0; lasts1 = 0; first1 = -1;
    send_frame(1, 64, 1'b1, 64);
    repeat (10) @(posedge clk);
    send_frame(1, 64, 1'b0, 64);
    wait_drain(1, 3000);
    chk("two_rx", rx1, 512);
    chk("two_lasts", lasts1, 2);
    chk("two_contig", last_c1 - first1 + 1, 512);
    chk("two_ovf", ovf1, 0);

    // Overflow: consumer stalled, second frame only fits its first word (63 in FIFO + 1 held).
    do_reset();
    rmode0 = 3;
    send_frame(0, 64, 1'b0, 64);
    send_frame(0, 64, 1'b0, 1);
    repeat (4) @(negedge clk);
`ifdef FFT_OSER_OVF_EN
    chk("ovf_set", ovf0, 1);
`else
    chk("ovf_set", ovf0, 0);
`endif
    chk("ovf_startok", start_ok0, 0);
    rx0 = 0;
    rmode0 = 0;
    wait_drain(0, 1000);
    chk("ovf_rx", rx0, 260);
`ifdef FFT_OSER_OVF_EN
    chk("ovf_sticky", ovf0, 1);
`else
    chk("ovf_sticky", ovf0, 0);
`endif

    // Reset while sample 100 of a frame sits on DOUT.
    do_reset();
    rmode0 = 0;
    send_frame(0, 64, 1'b1, 64);
    begin
      int n = 0;
      while (cnt0 < 100 && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("mid_reach", cnt0 >= 100, 1);
    end
    #1 rst_n = 0;
    clear_models();
    @(negedge clk);
    chk_rst("mid_rst");
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk_rst("mid_after");
    rx0 = 0; lasts0 = 0;
    send_frame(0, 64, 1'b1, 64);
    wait_drain(0, 1000);
    chk("mid_rx", rx0, 256);
    chk("mid_lasts", lasts0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_out_serializer.md
# fft_out_serializer

Output stage of the 4-bank FFT datapath, directly downstream of the FFT controller's output phase. While the controller's DONE is high, it captures one 4-lane word per cycle from the I/O buffer read ports into a word FIFO. It then serializes the words into a single-sample valid/ready stream with a frame-end marker. The controller cannot stall, so the block also exports a frame-credit signal that upstream logic uses to gate START.

## Interface
- DW, 16: bits per real/imag component; a sample is 2*DW bits, packed {re, im}.
- N_WORDS, 64: 4-lane words per frame, equal to the controller's output-phase length.
- DEPTH, 64: FIFO depth in words; must be a power of two and >= N_WORDS.
- RD_LAT, 1: cycles from DONE high to valid lane data at DIN0..DIN3.

- CLK  in  1  clock, rising edge
- RSTn  in  1  asynchronous active-low reset
- DONE  in  1  controller output-phase flag, high for N_WORDS consecutive cycles
- DIN0..DIN3  in  2*DW each  I/O buffer read lanes, already un-permuted, lane 0 = lowest sample index
- START_OK  out  1  registered; high when FIFO free words >= N_WORDS
- DOUT  out  2*DW  serialized sample
- DOUT_VALID  out  1  DOUT holds a valid sample
- DOUT_READY  in  1  consumer accepts DOUT this cycle
- DOUT_LAST  out  1  DOUT is sample 4*N_WORDS-1 of the frame
- OVF  out  1  sticky overflow flag (see Configuration)

## Operation
- Capture: DONE is delayed through an RD_LAT-stage shift register to form WE. On each cycle with WE high, {DIN3, DIN2, DIN1, DIN0} is pushed into the FIFO.
- FIFO: write pointer, read pointer, and occupancy counter of width log2(DEPTH)+1. A push and a pop in the same cycle leave occupancy unchanged. Pointers wrap modulo DEPTH.
- Holding register: four lanes plus a 2-bit lane index LI and a HOLD_VALID bit. A pop loads the holding register when HOLD_VALID is 0, or when LI==3 and a handshake (DOUT_VALID & DOUT_READY) occurs this cycle. This gives back-to-back words with no bubble.
- Output: DOUT = lane[LI]; DOUT_VALID = HOLD_VALID. On each handshake LI increments, wrapping 3->0. HOLD_VALID clears after lane 3 is taken if the FIFO is empty.
- Frame counter: width log2(4*N_WORDS) (8 bits by default). It increments on each handshake and wraps to 0 after 4*N_WORDS-1. DOUT_LAST = HOLD_VALID & (frame counter == 4*N_WORDS-1).
- Output state machine:
  - EMPTY -> LOADED on a pop.
  - LOADED stays LOADED through lanes 0-3 and on a chained pop.
  - LOADED -> EMPTY after lane 3 is handshaked with the FIFO empty.
- START_OK is registered from the next-cycle occupancy: (DEPTH - occ_next) >= N_WORDS.

## Timing
- Reset values: START_OK=1, DOUT=0, DOUT_VALID=0, DOUT_LAST=0, OVF=0, all pointers and counters 0, state EMPTY.
- DONE high in cycle t -> word written at the rising edge ending cycle t+RD_LAT.
- Word written at edge E with the holding register empty -> loaded at edge E+1 -> DOUT_VALID high in the cycle after E+1.
- Sustained throughput: 1 sample/cycle while DOUT_READY is held high. A frame drains in 4*N_WORDS cycles.
- DOUT, DOUT_VALID, and DOUT_LAST hold stable while DOUT_VALID=1 and DOUT_READY=0.
- With DEPTH=N_WORDS, START_OK rises one cycle after the final pop of a frame.
- Write when full: the word is dropped, pointers are unchanged, and OVF is set if enabled. A simultaneous pop makes the slot available, so the write proceeds.
- Reset mid-frame clears all state. A partial frame is discarded and the frame counter restarts at 0.

## Configuration
- FFT_OSER_OVF_EN defined: OVF sets on a write attempt while full with no simultaneous pop. It stays set until RSTn.
- FFT_OSER_OVF_EN undefined: OVF is tied to 0, there is no detection logic, and dropping words on full is silent.

## Structure
- Shared package fft_pkg holds:
  - DW and N_WORDS defaults, and lane count 4.
  - The sample type {re, im} and the 4-lane word type.
- Sub-module fft_oser_fifo: synchronous word FIFO with push/pop/occupancy/full/empty. The top level contains the delay line, holding register, frame counter, state machine, and START_OK.

## Test plan
- Reset released, no DONE -> START_OK=1, DOUT_VALID=0 for 100 cycles.
- DONE high 64 cycles, word k lanes = 4k..4k+3, DOUT_READY=1 -> samples 0..255 in order, one per cycle. DOUT_LAST only on 255. START_OK=0 from the first write until the drain completes.
- Same frame with DOUT_READY toggling 1,0,1,0 -> same sequence. DOUT is held during stalls; no loss, no duplication.
- Two frames with DEPTH=128, the second DONE starting 10 cycles after the first ends, READY=1 -> 512 contiguous samples. DOUT_LAST on samples 255 and 511.
- DOUT_READY=0, two 64-word frames with DEPTH=64 -> second frame dropped; OVF=1 with FFT_OSER_OVF_EN, OVF=0 without.
- Assert RSTn low at sample 100 of a frame -> all outputs return to reset values next cycle. A new frame afterwards starts at sample 0.
